// File: rtl/frogger_pkg.sv
// Shared frogger definitions: lane pixel geometry, frog coordinate widths
// and the collision FSM state type.
package frogger_pkg;

  localparam int LANE_WIDTH = 16;
  localparam int COL_W      = 4;
  localparam int ROW_W      = 4;

  typedef enum logic [1:0] {ALIVE, GRACE, DEAD} collision_state_t;

endpackage

// File: rtl/grace_timer.sv
// Loadable down-counter that times the post-respawn invulnerability window.
// done flags the edge on which the count reaches zero.
module grace_timer #(
  parameter int GRACE = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int GW = $clog2(GRACE + 1);

  logic [GW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = GW'(GRACE);
    end else if (count_q != '0) begin
      count_d = count_q - GW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == GW'(1));

endmodule

// File: rtl/frog_collision.sv
// Frog/car collision detection, life counter, respawn request and game-over.
//   state | meaning
//   ALIVE | counting consecutive overlapping samples
//   GRACE | invulnerable after a respawn, overlap ignored
//   DEAD  | game lost, lanes frozen until reset
module frog_collision
  import frogger_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LIVES     = 3,
  parameter int CONFIRM   = 2,
  parameter int GRACE     = 512
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] lane_pixels,
  input  logic [ROW_W-1:0]                frog_row,
  input  logic [COL_W-1:0]                frog_col,
  output logic [NUM_LANES-1:0]            hit,
  output logic                            respawn,
  output logic [$clog2(LIVES+1)-1:0]      lives,
  output logic                            game_over
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int CW = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM - 1);

  collision_state_t      state_q, state_d;
  logic [CW-1:0]         conf_q, conf_d;
  logic [LW-1:0]         lives_q, lives_d;
  logic                  respawn_q, respawn_d;
  logic [NUM_LANES-1:0]  hit_q, hit_d;
  logic                  game_over_q, game_over_d;
  logic [LANE_WIDTH-1:0] row_pix;
  logic                  overlap;
  logic                  grace_load;
  logic                  grace_done;

  // Rows at or beyond NUM_LANES select no lane, so they never overlap.
  always_comb begin
    row_pix = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (frog_row == ROW_W'(i)) begin
        row_pix = lane_pixels[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  assign overlap = row_pix[frog_col];

  grace_timer #(.GRACE(GRACE)) u_grace_timer (
    .clk   (clk),
    .reset (reset),
    .load  (grace_load),
    .done  (grace_done)
  );

  // The GRACE parameter shadows the imported state literal, hence the qualified name.
  always_comb begin
    state_d     = state_q;
    conf_d      = conf_q;
    lives_d     = lives_q;
    respawn_d   = 1'b0;
    hit_d       = '0;
    game_over_d = 1'b0;
    grace_load  = 1'b0;
    case (state_q)
      ALIVE: begin
        if (!overlap) begin
          conf_d = '0;
        end else if (conf_q != CONF_LAST) begin
          conf_d = conf_q + CW'(1);
        end else begin
          conf_d = '0;
          if (lives_q > LW'(1)) begin
            lives_d    = lives_q - LW'(1);
            respawn_d  = 1'b1;
            grace_load = 1'b1;
            state_d    = frogger_pkg::GRACE;
          end else begin
            lives_d     = '0;
            hit_d       = '1;
            game_over_d = 1'b1;
            state_d     = DEAD;
          end
        end
      end
      frogger_pkg::GRACE: begin
        conf_d = '0;
        if (grace_done) begin
          state_d = ALIVE;
        end
      end
      DEAD: begin
        conf_d      = '0;
        lives_d     = '0;
        hit_d       = '1;
        game_over_d = 1'b1;
      end
      default: begin
        state_d = ALIVE;
        conf_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ALIVE;
      conf_q      <= '0;
      lives_q     <= LW'(LIVES);
      respawn_q   <= 1'b0;
      hit_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      conf_q      <= conf_d;
      lives_q     <= lives_d;
      respawn_q   <= respawn_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
    end
  end

  assign hit       = hit_q;
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_frog_collision.sv
// Self-checking bench for frog_collision: directed scenarios with literal
// expectations plus a randomized run against a behavioural game model.
module tb_frog_collision;

  localparam int NUM_LANES = 4;
  localparam int LIVES     = 3;
  localparam int CONFIRM   = 2;
  localparam int GRACE     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] lane_pixels;
  logic [3:0]  frog_row;
  logic [3:0]  frog_col;
  logic [3:0]  hit;
  logic        respawn;
  logic [1:0]  lives;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  // Behavioural model: lives left, length of current overlap run,
  // samples still to ignore, and whether the game is lost.
  int m_lives   = LIVES;
  int m_run     = 0;
  int m_ignore  = 0;
  bit m_dead    = 1'b0;
  bit m_respawn = 1'b0;

  frog_collision #(
    .NUM_LANES (NUM_LANES),
    .LIVES     (LIVES),
    .CONFIRM   (CONFIRM),
    .GRACE     (GRACE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lane_pixels (lane_pixels),
    .frog_row    (frog_row),
    .frog_col    (frog_col),
    .hit         (hit),
    .respawn     (respawn),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit frog_on_car();
    if (frog_row >= NUM_LANES) return 1'b0;
    return lane_pixels[int'(frog_row) * 16 + int'(frog_col)];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lives   = LIVES;
      m_run     = 0;
      m_ignore  = 0;
      m_dead    = 1'b0;
      m_respawn = 1'b0;
    end else begin
      m_respawn = 1'b0;
      if (m_dead) begin
        m_run = 0;
      end else if (m_ignore > 0) begin
        m_ignore = m_ignore - 1;
        m_run    = 0;
      end else if (frog_on_car()) begin
        m_run = m_run + 1;
        if (m_run == CONFIRM) begin
          m_run = 0;
          if (m_lives > 1) begin
            m_lives   = m_lives - 1;
            m_respawn = 1'b1;
            m_ignore  = GRACE;
          end else begin
            m_lives = 0;
            m_dead  = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_lives", int'(lives), m_lives);
    check("model_respawn", int'(respawn), int'(m_respawn));
    check("model_game_over", int'(game_over), int'(m_dead));
    check("model_hit", int'(hit), m_dead ? 15 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    frog_row    = 4'd4;
    frog_col    = 4'd0;
    lane_pixels = '1;
    cyc(3);
    reset = 1'b0;

    // Safe row with every car pixel lit.
    cyc(50);
    check("idle_lives", int'(lives), 3);
    check("idle_hit", int'(hit), 0);
    check("idle_game_over", int'(game_over), 0);

    // First collision on lane 2, column 5.
    lane_pixels          = '0;
    lane_pixels[2*16+5]  = 1'b1;
    frog_row             = 4'd2;
    frog_col             = 4'd5;
    @(negedge clk);
    check("first_sample_lives", int'(lives), 3);
    check("first_sample_respawn", int'(respawn), 0);
    @(negedge clk);
    check("confirm_respawn", int'(respawn), 1);
    check("confirm_lives", int'(lives), 2);
    cyc(8);
    check("grace_lives", int'(lives), 2);
    check("grace_respawn", int'(respawn), 0);
    cyc(2);
    check("second_hit_lives", int'(lives), 1);
    check("second_hit_respawn", int'(respawn), 1);

    // Let grace expire off the road, then a broken run.
    frog_row = 4'd4;
    cyc(10);
    frog_row = 4'd2;
    @(negedge clk);
    frog_row = 4'd4;
    @(negedge clk);
    frog_row = 4'd2;
    @(negedge clk);
    frog_row = 4'd4;
    @(negedge clk);
    check("gap_lives", int'(lives), 1);

    // Final collision.
    frog_row = 4'd2;
    cyc(2);
    check("dead_lives", int'(lives), 0);
    check("dead_game_over", int'(game_over), 1);
    check("dead_hit", int'(hit), 15);
    check("dead_respawn", int'(respawn), 0);
    for (int i = 0; i < 20; i++) begin
      frog_row    = 4'($urandom_range(0, 5));
      frog_col    = 4'($urandom_range(0, 15));
      lane_pixels = {$urandom, $urandom};
      @(negedge clk);
    end
    check("dead_hold_lives", int'(lives), 0);
    check("dead_hold_hit", int'(hit), 15);

    // Asynchronous reset out of DEAD.
    #2 reset = 1'b1;
    #1;
    check("rst_dead_lives", int'(lives), 3);
    check("rst_dead_hit", int'(hit), 0);
    check("rst_dead_game_over", int'(game_over), 0);
    check("rst_dead_respawn", int'(respawn), 0);
    lane_pixels         = '0;
    lane_pixels[2*16+5] = 1'b1;
    frog_row            = 4'd2;
    frog_col            = 4'd5;
    @(negedge clk);
    #2 reset = 1'b0;
    cyc(2);
    check("after_rst_collide", int'(lives), 2);
    cyc(3);

    // Asynchronous reset mid-grace, then counting restarts immediately.
    #2 reset = 1'b1;
    #1;
    check("rst_grace_lives", int'(lives), 3);
    check("rst_grace_respawn", int'(respawn), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    cyc(2);
    check("alive_after_grace_rst", int'(lives), 2);

    // Column 15 is the MSB of the lane row.
    #2 reset = 1'b1;
    lane_pixels = 64'h0000_0000_0000_8000;
    frog_row    = 4'd0;
    frog_col    = 4'd15;
    @(negedge clk);
    #2 reset = 1'b0;
    cyc(2);
    check("col15_hit_lives", int'(lives), 2);
    #2 reset = 1'b1;
    frog_col = 4'd14;
    @(negedge clk);
    #2 reset = 1'b0;
    cyc(2);
    check("col14_miss_lives", int'(lives), 3);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) pulse_reset();
      if ($urandom_range(0, 3) == 0) begin
        frog_row = 4'($urandom_range(0, 5));
        frog_col = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       lane_pixels = '0;
          1:       lane_pixels = '1;
          default: lane_pixels = {$urandom, $urandom};
        endcase
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_collision.md
Name: frog_collision

Overview:
- Consumer side of the lane pixel interface: takes the 16-bit pixel rows driven by every car lane, compares them against the frog's row/column, and decides when the frog has been hit.
- Owns the life counter, respawn request and game-over.
- Drives the per-lane `hit` inputs that freeze the lane generators into their blank state once the game is lost.

Parameters:
- NUM_LANES, 4: number of car lanes; lane i occupies frog rows i.
- LIVES, 3: lives at reset; must be >= 1.
- CONFIRM, 2: consecutive overlapping cycles required to register a collision; must be >= 1.
- GRACE, 512: invulnerability cycles after a respawn; must be >= 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- lane_pixels, input, 16*NUM_LANES: lane i row at [16*i +: 16]; bit c = column c; 1 = car present.
- frog_row, input, 4: frog row; values >= NUM_LANES are safe rows (no lane).
- frog_col, input, 4: frog column 0..15.
- hit, output, NUM_LANES: per-lane hit to the lane generators; all ones only in DEAD.
- respawn, output, 1: one-cycle pulse requesting the frog be returned to start.
- lives, output, $clog2(LIVES+1): remaining lives.
- game_over, output, 1: high in DEAD.

Behaviour:
- Outputs are registered. Reset values: hit=0, respawn=0, lives=LIVES, game_over=0, state ALIVE, confirm count 0, grace count 0.
- overlap (combinational) = (frog_row < NUM_LANES) && lane_pixels[16*frog_row + frog_col]. Inputs are sampled on each rising clk edge.
- ALIVE:
  - overlap increments confirm count.
  - !overlap clears confirm count to 0. A broken run restarts counting.
  - At the edge where overlap is sampled and count == CONFIRM-1, a collision is confirmed. Confirm count is cleared to 0.
  - Confirmed with lives > 1: lives decrements, respawn=1 for exactly the next cycle, grace count loads GRACE, go to GRACE.
  - Confirmed with lives == 1: lives=0, go to DEAD. No respawn pulse is issued.
- GRACE:
  - overlap is ignored and confirm count is held at 0.
  - grace count decrements each cycle. At the edge where it reaches 0, go to ALIVE.
  - Counting restarts fresh on the first ALIVE sample.
  - Total ignored samples = GRACE.
- DEAD:
  - Terminal until reset. hit = all ones, game_over=1, respawn=0, lives=0.
  - All inputs are ignored.
- Latency: with CONFIRM=N, overlap sampled on edges k..k+N-1 gives respawn/lives/DEAD visible after edge k+N-1.
- CONFIRM=1: a single overlapping sample confirms.
- frog_row/frog_col changes mid-run: only overlap of the current sample matters. Moving off a car breaks the run.
- Reset asserted in any state (including mid-GRACE or DEAD) returns all outputs to reset values immediately, without waiting for a clock edge.
- lives never underflows. hit is never asserted outside DEAD.

Decomposition:
- Package `frogger_pkg`:
  - constant LANE_WIDTH=16; constant COL_W=4, ROW_W=4.
  - typedef enum {ALIVE, GRACE, DEAD} collision_state_t.
  - Shared with the lane generators and frog controller.
- One natural sub-module, `grace_timer`: a loadable down-counter with a `load` input, a `GRACE` parameter and a `done` output. The FSM instantiates it for the GRACE state.

Test Plan (NUM_LANES=4, LIVES=3, CONFIRM=2, GRACE=8):
- Reset, then idle with frog_row=4 and all lane_pixels=1 for 50 cycles -> lives=3, hit=0000, respawn never high, game_over=0.
- frog_row=2, frog_col=5, lane 2 bit 5=1 for 2 cycles -> respawn high exactly 1 cycle after the 2nd edge, lives=2. Overlap held for the next 8 cycles -> no change. After 2 further overlapping cycles -> lives=1.
- Overlap 1 cycle, clear 1 cycle, overlap 1 cycle -> no life lost. Confirm count verified cleared by the gap.
- Three confirmed collisions (separated by grace) -> 3rd collision gives lives=0, game_over=1, hit=1111, no respawn pulse. Further overlaps/moves for 20 cycles change nothing.
- Assert reset asynchronously (between clock edges) mid-GRACE and in DEAD -> lives=3, hit=0000, game_over=0, respawn=0 immediately. ALIVE counting works after release.
- frog_col=15, lane 0 row=16'h8000, frog_row=0 for 2 cycles -> collision confirmed. Same with frog_col=14 -> none (bit mapping check).
